// File: rtl/load_aligner.sv
// RV32I load data aligner: captures a load request, waits for the memory word,
// then shifts and extends it for writeback. LOAD_ALIGNER_TIMEOUT_EN enables a WAIT timeout.
module load_aligner #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [4:0]  req_rd,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends combinationally on ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("load_aligner: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_q;
    logic [4:0]  rd_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        misalign_q;
    logic        req_legal;
    logic [31:0] shifted;
    logic [31:0] load_data_d;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            F3_LB, F3_LBU: req_legal = 1'b1;
            F3_LH, F3_LHU: req_legal = ~req_addr_lo[0];
            F3_LW:         req_legal = (req_addr_lo == 2'b00);
            default:       req_legal = 1'b0;
        endcase
    end

    always_comb begin
        shifted     = mem_rdata >> {addr_q, 3'b000};
        load_data_d = shifted;
        case (funct3_q)
            F3_LB:   load_data_d = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data_d = {24'h000000, shifted[7:0]};
            F3_LH:   load_data_d = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data_d = {16'h0000, shifted[15:0]};
            default: load_data_d = shifted;
        endcase
    end

`ifdef LOAD_ALIGNER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       timeout_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'b000;
            addr_q     <= 2'b00;
            rd_q       <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            misalign_q <= 1'b0;
`ifdef LOAD_ALIGNER_TIMEOUT_EN
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
`ifdef LOAD_ALIGNER_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr_lo;
                        rd_q     <= req_rd;
                        if (req_legal) begin
                            state_q <= S_WAIT;
`ifdef LOAD_ALIGNER_TIMEOUT_EN
                            cnt_q   <= 8'd0;
`endif
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Data arriving on the final counted cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        wb_data_q <= load_data_d;
                        wb_rd_q   <= rd_q;
                        state_q   <= S_HOLD;
                    end
`ifdef LOAD_ALIGNER_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (wb_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign wb_valid     = (state_q == S_HOLD);
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign misalign_err = misalign_q;
    assign dbg_state_o  = state_q;
`ifdef LOAD_ALIGNER_TIMEOUT_EN
    assign timeout_err  = timeout_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_load_aligner.sv
// Scoreboard bench for load_aligner: directed loads, illegal requests, HOLD stalls,
// timeout (when LOAD_ALIGNER_TIMEOUT_EN is defined) and mid-WAIT reset.
module tb_load_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [1:0]  req_addr_lo = 2'b00;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign_err;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    load_aligner #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr_lo  (req_addr_lo),
        .req_rd       (req_rd),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];
    int          hold_cnt = 0;
    int          last_hold = 0;
    logic [36:0] hold_prev = '0;
    int          mis_seen = 0;
    int          to_seen = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [36:0] e;
        if (wb_valid) begin
            hold_cnt++;
            if (hold_cnt > 1) check("hold_stable", {wb_rd, wb_data}, hold_prev);
            hold_prev = {wb_rd, wb_data};
            if (wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_data", wb_data, e[31:0]);
                    check("wb_rd", wb_rd, e[36:32]);
                end
                last_hold = hold_cnt;
                hold_cnt  = 0;
            end
        end else begin
            hold_cnt = 0;
        end
        if (misalign_err) mis_seen++;
        if (timeout_err) to_seen++;
        if (misalign_err || timeout_err)
            check("err_exclusive", {misalign_err && timeout_err, (misalign_err || timeout_err) && wb_valid}, 0);
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] exp,
                           input int gap, input int stall, input bit noise);
        check("req_ready_idle", req_ready, 1);
        req_valid   = 1'b1;
        req_funct3  = f3;
        req_addr_lo = lo;
        req_rd      = rd;
        mem_rvalid  = noise;
        mem_rdata   = 32'h5A5A_A5A5;
        exp_q.push_back({rd, exp});
        @(posedge clk); #1;
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        check("req_ready_wait", req_ready, 0);
        repeat (gap) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        check("wb_valid_latency", wb_valid, 1);
        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~rdata;
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        check("idle_after_hs", {wb_valid, req_ready}, 2'b01);
        check("hold_len", last_hold, stall + 1);
    endtask

    task automatic do_illegal(input logic [2:0] f3, input logic [1:0] lo);
        check("req_ready_illegal", req_ready, 1);
        req_valid   = 1'b1;
        req_funct3  = f3;
        req_addr_lo = lo;
        req_rd      = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("misalign_pulse", {misalign_err, req_ready, wb_valid}, 3'b110);
        @(posedge clk); #1;
        check("misalign_clear", {misalign_err, req_ready, wb_valid}, 3'b010);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {wb_valid, misalign_err, timeout_err, wb_rd, wb_data}, 0);
        check("reset_ready", req_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", req_ready, 1);

        do_load(3'b000, 2'd3, 5'd5,  32'h80FF_1234, 32'hFFFF_FF80, 0, 0, 1'b1);
        do_load(3'b101, 2'd2, 5'd6,  32'h8001_7FFF, 32'h0000_8001, 1, 0, 1'b0);
        do_load(3'b001, 2'd2, 5'd7,  32'h8001_7FFF, 32'hFFFF_8001, 2, 0, 1'b0);
        do_load(3'b010, 2'd0, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1'b0);
        do_load(3'b100, 2'd1, 5'd8,  32'h80FF_1234, 32'h0000_0012, 0, 0, 1'b0);
        do_load(3'b000, 2'd2, 5'd9,  32'h80FF_1234, 32'hFFFF_FFFF, 0, 0, 1'b0);
        do_load(3'b001, 2'd0, 5'd10, 32'h8001_7FFF, 32'h0000_7FFF, 0, 0, 1'b0);
        do_load(3'b100, 2'd0, 5'd0,  32'h80FF_1234, 32'h0000_0034, 0, 0, 1'b0);
        // stall HOLD for 5 cycles with stray mem_rvalid pulses
        do_load(3'b010, 2'd0, 5'd12, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 5, 1'b1);

        do_illegal(3'b010, 2'd1);
        do_illegal(3'b011, 2'd0);
        do_illegal(3'b001, 2'd1);
        do_illegal(3'b110, 2'd0);
        do_illegal(3'b111, 2'd2);
        do_illegal(3'b101, 2'd3);

`ifdef LOAD_ALIGNER_TIMEOUT_EN
        check("req_ready_to", req_ready, 1);
        req_valid   = 1'b1;
        req_funct3  = 3'b010;
        req_addr_lo = 2'd0;
        req_rd      = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("to_waiting", {timeout_err, req_ready}, 2'b00);
        end
        @(posedge clk); #1;
        check("to_pulse", {timeout_err, req_ready, wb_valid}, 3'b110);
        @(posedge clk); #1;
        check("to_clear", timeout_err, 0);
        do_load(3'b010, 2'd0, 5'd9, 32'h1234_5678, 32'h1234_5678, 3, 0, 1'b0);
`else
        do_load(3'b010, 2'd0, 5'd9, 32'h1234_5678, 32'h1234_5678, 10, 0, 1'b0);
`endif

        // reset in the middle of WAIT, then a stale memory response
        req_valid   = 1'b1;
        req_funct3  = 3'b010;
        req_addr_lo = 2'd0;
        req_rd      = 5'd13;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_async_outs", {wb_valid, misalign_err, timeout_err, wb_rd, wb_data}, 0);
        check("rst_async_ready", req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_release_ready", req_ready, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stale_rvalid", {wb_valid, req_ready, wb_data}, {1'b0, 1'b1, 32'd0});
        end

        check("queue_empty", exp_q.size(), 0);
        check("misalign_count", mis_seen, 6);
`ifdef LOAD_ALIGNER_TIMEOUT_EN
        check("timeout_count", to_seen, 1);
`else
        check("timeout_count", to_seen, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_aligner.md
LOAD_ALIGNER -- requirements
Module: load_aligner

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before a timeout; legal range 1..255, 8-bit counter.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_funct3  input  3  RV32I load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 req_addr_lo  input  2  byte offset, address bits [1:0].
REQ-008 req_rd  input  5  destination register index.
REQ-009 mem_rvalid  input  1  memory read data valid, one-cycle pulse.
REQ-010 mem_rdata  input  32  word-aligned memory read data.
REQ-011 wb_valid  output  1  aligned result available.
REQ-012 wb_ready  input  1  writeback accepts the result.
REQ-013 wb_data  output  32  aligned and extended load result.
REQ-014 wb_rd  output  5  destination register for wb_data.
REQ-015 misalign_err  output  1  one-cycle pulse: misaligned or illegal request.
REQ-016 timeout_err  output  1  one-cycle pulse: memory response timed out.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and HOLD; req_ready=1 only in IDLE; wb_valid=1 only in HOLD.
REQ-018 IDLE with req_valid SHALL register funct3, addr_lo and rd.
REQ-019 Next state after REQ-018: WAIT if the request is legal; otherwise stay IDLE and pulse misalign_err on the following cycle.
REQ-020 Illegal requests: funct3 in {011,110,111}; LH/LHU with addr_lo[0]=1; LW with addr_lo!=00.
REQ-021 mem_rvalid outside WAIT, including the cycle a request is accepted, SHALL be ignored.
REQ-022 WAIT with mem_rvalid SHALL register wb_data and go to HOLD; the first possible wb_valid is 1 cycle after mem_rvalid.
REQ-023 Alignment: shifted = mem_rdata >> (8*addr_lo).
REQ-024 Extension: LB sign-extends shifted[7:0]; LBU zero-extends shifted[7:0]; LH sign-extends shifted[15:0]; LHU zero-extends shifted[15:0]; LW passes shifted unchanged.
REQ-025 HOLD SHALL keep wb_data and wb_rd stable until wb_ready=1, then return to IDLE on the next edge.
REQ-026 There SHALL be no back-to-back bypass: a new request is accepted no earlier than the cycle after the HOLD handshake.
REQ-027 A request with rd=0 SHALL still complete through HOLD; suppressing the write is the register file's job.
REQ-028 The WAIT counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_rvalid.
REQ-029 When the counter reaches TIMEOUT_CYCLES without mem_rvalid, the block SHALL pulse timeout_err, go to IDLE and produce no wb_valid.
REQ-030 If mem_rvalid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the data SHALL win: go to HOLD with no timeout_err.
REQ-031 misalign_err and timeout_err SHALL never assert in the same cycle and SHALL never assert together with wb_valid.

Reset
REQ-032 rst=1 SHALL immediately force IDLE and set wb_valid=0, misalign_err=0, timeout_err=0, wb_data=0, wb_rd=0 and counter=0.
REQ-033 Reset in WAIT or HOLD SHALL discard the captured request; a later mem_rvalid SHALL produce no output.
REQ-034 req_ready SHALL equal 1 in the first cycle after rst deasserts.

Configuration
REQ-035 Macro LOAD_ALIGNER_TIMEOUT_EN defined: the counter and timeout_err SHALL behave per REQ-028 to REQ-030.
REQ-036 Macro LOAD_ALIGNER_TIMEOUT_EN undefined: there SHALL be no counter; WAIT lasts until mem_rvalid; timeout_err SHALL be tied to 0; TIMEOUT_CYCLES is ignored.

Verification
REQ-037 LB, addr_lo=11, mem_rdata=0x80FF_1234 -> wb_data=0xFFFF_FF80 and wb_rd equals req_rd, 1 cycle after mem_rvalid.
REQ-038 LHU, addr_lo=10, mem_rdata=0x8001_7FFF -> wb_data=0x0000_8001; LH with the same inputs -> 0xFFFF_8001; LW, addr_lo=00, mem_rdata=0xDEAD_BEEF -> 0xDEAD_BEEF.
REQ-039 LW with addr_lo=01, then funct3=011 -> misalign_err pulses once each, no wb_valid, req_ready stays 1.
REQ-040 Result in HOLD with wb_ready=0 for 5 cycles, then 1 -> wb_valid held high and wb_data stable for 6 cycles; IDLE on the next cycle; a mem_rvalid during HOLD is ignored.
REQ-041 With LOAD_ALIGNER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: no mem_rvalid -> one timeout_err pulse, then IDLE; repeat with mem_rvalid on the 4th WAIT cycle -> HOLD and no timeout_err.
REQ-042 rst asserted mid-WAIT, then mem_rvalid after release -> no wb_valid, all outputs 0, req_ready=1.
